// File: rtl/booth_op_sequencer_pkg.sv
// Shared state encoding and default geometry for the Booth multiplier front-end sequencer.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } booth_seq_state_t;

  localparam int BOOTH_IW          = 6;
  localparam int BOOTH_OW          = 12;
  localparam int BOOTH_CS          = 4;
  localparam int BOOTH_DONE_COUNT  = 7;
  localparam int BOOTH_LOAD_CYCLES = 2;
  localparam int BOOTH_TIMEOUT     = 16;

  // Watchdog width: must be able to hold TIMEOUT itself so the count saturates instead of wrapping.
  function automatic int booth_wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/booth_op_sequencer_if.sv
// Operand request and product response handshakes between a client and the Booth sequencer.
interface booth_op_sequencer_if #(
  parameter int IW = booth_pkg::BOOTH_IW,
  parameter int OW = booth_pkg::BOOTH_OW
);

  logic          op_valid_in;
  logic          op_ready_out;
  logic [IW-1:0] multiplicand_in;
  logic [IW-1:0] multiplier_in;
  logic          res_valid_out;
  logic          res_ready_in;
  logic [OW-1:0] res_product_out;

  modport slave (
    input  op_valid_in,
    input  multiplicand_in,
    input  multiplier_in,
    input  res_ready_in,
    output op_ready_out,
    output res_valid_out,
    output res_product_out
  );

  modport master (
    output op_valid_in,
    output multiplicand_in,
    output multiplier_in,
    output res_ready_in,
    input  op_ready_out,
    input  res_valid_out,
    input  res_product_out
  );

endinterface

// File: rtl/booth_op_sequencer_watchdog.sv
// Run-phase watchdog: clearable, enabled up-counter that saturates at TIMEOUT.
// expired is combinational and asserts on the TIMEOUT-th enabled cycle after a clear.
module booth_seq_watchdog
  import booth_pkg::*;
#(
  parameter  int TIMEOUT = BOOTH_TIMEOUT,
  localparam int W       = booth_wd_width(TIMEOUT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != W'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/booth_op_sequencer.sv
// Booth core front-end: load operands, wait for step counter, return product (opt. BOOTH_SEQ_SELFCHECK_EN).
// Latency: LOAD_CYCLES + run cycles + 1 from operand handshake to res_valid_out; one op in flight.
// Backpressure: op_ready_out low while busy; product held in DONE until res_ready_in.
module booth_op_sequencer
  import booth_pkg::*;
#(
  parameter int INPUT_WIDTH  = BOOTH_IW,
  parameter int OUTPUT_WIDTH = BOOTH_OW,
  parameter int COUNTER_SIZE = BOOTH_CS,
  parameter int DONE_COUNT   = BOOTH_DONE_COUNT,
  parameter int LOAD_CYCLES  = BOOTH_LOAD_CYCLES,
  parameter int TIMEOUT      = BOOTH_TIMEOUT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  booth_op_sequencer_if.slave     io,
  output logic                    mul_rst_out,
  output logic [INPUT_WIDTH-1:0]  mul_multiplicand_out,
  output logic [INPUT_WIDTH-1:0]  mul_multiplier_out,
  input  logic [OUTPUT_WIDTH-1:0] mul_product_in,
  input  logic [COUNTER_SIZE-1:0] mul_counter_in,
  output logic                    busy_out,
  output logic                    timeout_out,
  output logic                    mismatch_out
);

  localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  generate
    if (OUTPUT_WIDTH != 2 * INPUT_WIDTH) begin : g_bad_output_width
      $error("booth_op_sequencer: OUTPUT_WIDTH must equal 2*INPUT_WIDTH");
    end
    if (LOAD_CYCLES < 1) begin : g_bad_load_cycles
      $error("booth_op_sequencer: LOAD_CYCLES must be at least 1");
    end
    if (TIMEOUT < DONE_COUNT) begin : g_bad_timeout
      $error("booth_op_sequencer: TIMEOUT must be at least DONE_COUNT");
    end
  endgenerate

  booth_seq_state_t        state_q, state_n;
  logic                    op_ready_q, op_ready_n;
  logic                    mul_rst_q, mul_rst_n;
  logic                    res_valid_q, res_valid_n;
  logic                    busy_q, busy_n;
  logic                    timeout_q, timeout_n;
  logic [OUTPUT_WIDTH-1:0] product_q, product_n;
  logic [INPUT_WIDTH-1:0]  a_q, a_n;
  logic [INPUT_WIDTH-1:0]  b_q, b_n;
  logic [LCW-1:0]          load_cnt_q, load_cnt_n;
  logic                    counter_done;
  logic                    wd_expired;

  assign counter_done = (mul_counter_in == COUNTER_SIZE'(DONE_COUNT));

  booth_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .clear   (state_q != RUN),
    .enable  (state_q == RUN),
    .expired (wd_expired)
  );

  always_comb begin
    state_n     = state_q;
    op_ready_n  = 1'b0;
    mul_rst_n   = 1'b1;
    res_valid_n = 1'b0;
    timeout_n   = timeout_q;
    product_n   = product_q;
    a_n         = a_q;
    b_n         = b_q;
    load_cnt_n  = load_cnt_q;

    unique case (state_q)
      IDLE: begin
        op_ready_n = 1'b1;
        if (io.op_valid_in && op_ready_q) begin
          a_n        = io.multiplicand_in;
          b_n        = io.multiplier_in;
          load_cnt_n = '0;
          op_ready_n = 1'b0;
          state_n    = LOAD;
        end
      end

      LOAD: begin
        if (load_cnt_q == LCW'(LOAD_CYCLES - 1)) begin
          mul_rst_n = 1'b0;
          state_n   = RUN;
        end else begin
          load_cnt_n = load_cnt_q + 1'b1;
        end
      end

      RUN: begin
        mul_rst_n = 1'b0;
        // A final counter on the watchdog's last cycle still counts as a good result.
        if (counter_done) begin
          product_n   = mul_product_in;
          res_valid_n = 1'b1;
          mul_rst_n   = 1'b1;
          state_n     = DONE;
        end else if (wd_expired) begin
          product_n   = '0;
          timeout_n   = 1'b1;
          res_valid_n = 1'b1;
          mul_rst_n   = 1'b1;
          state_n     = DONE;
        end
      end

      DONE: begin
        res_valid_n = 1'b1;
        if (res_valid_q && io.res_ready_in) begin
          res_valid_n = 1'b0;
          op_ready_n  = 1'b1;
          state_n     = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      op_ready_q  <= 1'b0;
      mul_rst_q   <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      product_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      load_cnt_q  <= '0;
    end else begin
      state_q     <= state_n;
      op_ready_q  <= op_ready_n;
      mul_rst_q   <= mul_rst_n;
      res_valid_q <= res_valid_n;
      busy_q      <= busy_n;
      timeout_q   <= timeout_n;
      product_q   <= product_n;
      a_q         <= a_n;
      b_q         <= b_n;
      load_cnt_q  <= load_cnt_n;
    end
  end

`ifdef BOOTH_SEQ_SELFCHECK_EN
  logic signed [2*INPUT_WIDTH-1:0] ref_product;
  logic                            capture;
  logic                            mismatch_q;

  assign ref_product = $signed({{INPUT_WIDTH{a_q[INPUT_WIDTH-1]}}, a_q})
                     * $signed({{INPUT_WIDTH{b_q[INPUT_WIDTH-1]}}, b_q});
  assign capture     = (state_q == RUN) && counter_done;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mismatch_q <= 1'b0;
    end else if (capture && (mul_product_in != OUTPUT_WIDTH'(ref_product))) begin
      mismatch_q <= 1'b1;
    end
  end

  assign mismatch_out = mismatch_q;
`else
  assign mismatch_out = 1'b0;
`endif

  assign io.op_ready_out      = op_ready_q;
  assign io.res_valid_out     = res_valid_q;
  assign io.res_product_out   = product_q;
  assign mul_rst_out          = mul_rst_q;
  assign mul_multiplicand_out = a_q;
  assign mul_multiplier_out   = b_q;
  assign busy_out             = busy_q;
  assign timeout_out          = timeout_q;

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Scoreboard bench: behavioural Booth core stand-in, random operands, directed timeout/hold/reset cases.
`timescale 1ns/1ps
module tb_booth_op_sequencer;
  import booth_pkg::*;

  localparam int IW = 6;
  localparam int OW = 12;
  localparam int CS = 4;
  localparam int DC = 7;
  localparam int LC = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_op_sequencer_if #(.IW(IW), .OW(OW)) bus ();

  logic          mul_rst;
  logic [IW-1:0] mcand, mplier;
  logic [OW-1:0] core_product;
  logic [CS-1:0] core_cnt = '0;
  logic          busy, tmo, mism;

  booth_op_sequencer #(
    .INPUT_WIDTH (IW), .OUTPUT_WIDTH(OW), .COUNTER_SIZE(CS),
    .DONE_COUNT  (DC), .LOAD_CYCLES (LC), .TIMEOUT     (TO)
  ) dut (
    .clk_in               (clk),
    .rst_in               (rst_n),
    .io                   (bus),
    .mul_rst_out          (mul_rst),
    .mul_multiplicand_out (mcand),
    .mul_multiplier_out   (mplier),
    .mul_product_in       (core_product),
    .mul_counter_in       (core_cnt),
    .busy_out             (busy),
    .timeout_out          (tmo),
    .mismatch_out         (mism)
  );

  // Core stand-in: counts steps after load, presents the (optionally corrupted) product once final.
  logic stuck   = 1'b0;
  logic corrupt = 1'b0;
  always @(posedge clk) begin
    if (mul_rst) core_cnt <= '0;
    else if (!stuck && core_cnt != CS'(DC)) core_cnt <= core_cnt + 1'b1;
  end
  always_comb begin
    int p;
    p = int'($signed(mcand)) * int'($signed(mplier));
    core_product = (core_cnt == CS'(DC)) ? (OW'(p) ^ {{(OW-1){1'b0}}, corrupt}) : '0;
  end

  typedef struct packed {
    logic [OW-1:0] prod;
    logic          tmo;
    logic          mism;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic tmo_sticky  = 1'b0;
  logic mism_sticky = 1'b0;
  logic hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic logic [OW-1:0] ref_prod(input logic [IW-1:0] a, input logic [IW-1:0] b);
    int ia, ib, p;
    ia = $signed(a);
    ib = $signed(b);
    p  = ia * ib;
    return p[OW-1:0];
  endfunction

  task automatic send_op(input int a, input int b);
    logic [IW-1:0] av, bv;
    exp_t e;
    int   n;
    av = a[IW-1:0];
    bv = b[IW-1:0];
    n  = 0;
    @(negedge clk);
    while (!bus.op_ready_out && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.op_ready_out) begin
      timeout_fail("op_ready_wait");
      return;
    end
    if (stuck) begin
      tmo_sticky = 1'b1;
      e.prod     = '0;
    end else begin
      e.prod = ref_prod(av, bv) ^ {{(OW-1){1'b0}}, corrupt};
`ifdef BOOTH_SEQ_SELFCHECK_EN
      if (corrupt) mism_sticky = 1'b1;
`endif
    end
    e.tmo  = tmo_sticky;
    e.mism = mism_sticky;
    sb.push_back(e);
    bus.multiplicand_in = av;
    bus.multiplier_in   = bv;
    bus.op_valid_in     = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid_in     = 1'b0;
    bus.multiplicand_in = IW'($urandom);
    bus.multiplier_in   = IW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.op_ready_out) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !bus.op_ready_out) timeout_fail("idle_wait");
  endtask

  // Consumer: random backpressure unless a hold is requested.
  initial begin
    bus.res_ready_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.res_ready_in = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: scoreboard pops plus result-stability while stalled.
  exp_t          e_mon;
  logic          prev_hold = 1'b0;
  logic [OW-1:0] prev_prod = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("stall_valid", bus.res_valid_out, 1);
        check("stall_product", bus.res_product_out, prev_prod);
        check("stall_op_ready", bus.op_ready_out, 0);
      end
      if (bus.res_valid_out && bus.res_ready_in) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got 0x%0h, expected no result", bus.res_product_out);
        end else begin
          e_mon = sb.pop_front();
          check("product", bus.res_product_out, e_mon.prod);
          check("timeout", tmo, e_mon.tmo);
          check("mismatch", mism, e_mon.mism);
        end
      end
      prev_hold = bus.res_valid_out && !bus.res_ready_in;
      prev_prod = bus.res_product_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    bus.op_valid_in     = 1'b0;
    bus.multiplicand_in = '0;
    bus.multiplier_in   = '0;
    #12;
    check("rst_op_ready", bus.op_ready_out, 0);
    check("rst_mul_rst", mul_rst, 1);
    check("rst_res_valid", bus.res_valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", tmo, 0);
    check("rst_mismatch", mism, 0);
    check("rst_product", bus.res_product_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_op_ready_low", bus.op_ready_out, 0);
    @(posedge clk);
    #1;
    check("rel_op_ready_high", bus.op_ready_out, 1);

    // Directed back-to-back operands.
    send_op(31, 24);
    send_op(-20, -31);
    send_op(-23, -17);
    wait_idle();

    // Consumer holds off for 5 cycles in DONE.
    hold = 1'b1;
    send_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    n = 0;
    while (!bus.res_valid_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid_out) timeout_fail("hold_valid_wait");
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", bus.res_valid_out, 1);
      check("hold_op_ready", bus.op_ready_out, 0);
    end
    hold = 1'b0;
    wait_idle();

    for (int i = 0; i < 20; i++) begin
      send_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    // Stalled core: watchdog must return a zero product and a sticky timeout.
    stuck = 1'b1;
    send_op(13, -9);
    wait_idle();
    check("busy_after_timeout", busy, 0);
    stuck = 1'b0;
    send_op(-32, -32);
    wait_idle();

    // Asynchronous reset while the core is running.
    send_op(17, 11);
    n = 0;
    while (mul_rst && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (mul_rst) timeout_fail("run_wait");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    tmo_sticky  = 1'b0;
    mism_sticky = 1'b0;
    check("abort_op_ready", bus.op_ready_out, 0);
    check("abort_mul_rst", mul_rst, 1);
    check("abort_res_valid", bus.res_valid_out, 0);
    check("abort_busy", busy, 0);
    check("abort_timeout", tmo, 0);
    check("abort_product", bus.res_product_out, 0);
    check("abort_operand", mcand, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_op(5, -3);
    wait_idle();

    // Corrupted core product: passed through verbatim, flagged only by the self-check build.
    corrupt = 1'b1;
    send_op(-7, 9);
    wait_idle();
    corrupt = 1'b0;
    send_op(3, 4);
    wait_idle();

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
